ov7670_frame_capture: RTL and testbench

- Next-generation OV7670 pixel capture engine; single system-clock domain.
- Oversamples the raw camera bus (pclk, href, vsync, data) and pairs bytes into pixels.
- Applies power-of-two decimation, pixel-format conversion and single-shot/continuous capture control, then emits frame-buffer write strobes.
- Sits between the camera pins and the frame-buffer RAM, alongside the SCCB configuration block.

---
 rtl/ov7670_pkg.sv | 23 ++
 rtl/ov7670_pix_convert.sv | 40 ++++
 rtl/ov7670_frame_capture.sv | 194 +++++++++++++++++++
 tb/tb_ov7670_frame_capture.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path and display-side reuse.
package ov7670_pkg;

    typedef enum logic [1:0] {
        FMT_RGB565 = 2'd0,
        FMT_RGB444 = 2'd1,
        FMT_GRAY8  = 2'd2
    } pix_fmt_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_START,
        ST_CAPTURE,
        ST_DONE
    } cap_state_e;

    // BT.601-style luma weights scaled by 256
    localparam int unsigned LUMA_R = 77;
    localparam int unsigned LUMA_G = 150;
    localparam int unsigned LUMA_B = 29;

endpackage

// File: rtl/ov7670_pix_convert.sv
// Combinational RGB565 -> RGB565/RGB444/GRAY8 converter; reserved format passes RGB565 through.
module ov7670_pix_convert
    import ov7670_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic [15:0] i_pix,
    output logic [15:0] o_data_c
);

    logic [4:0]  w_r5;
    logic [5:0]  w_g6;
    logic [4:0]  w_b5;
    logic [7:0]  w_r8;
    logic [7:0]  w_g8;
    logic [7:0]  w_b8;
    logic [15:0] w_luma;

    assign w_r5 = i_pix[15:11];
    assign w_g6 = i_pix[10:5];
    assign w_b5 = i_pix[4:0];

    // Expand to 8 bits by replicating MSBs so full scale maps to 0xFF
    assign w_r8 = {w_r5, w_r5[4:2]};
    assign w_g8 = {w_g6, w_g6[5:4]};
    assign w_b8 = {w_b5, w_b5[4:2]};

    assign w_luma = 16'(LUMA_R) * 16'(w_r8)
                  + 16'(LUMA_G) * 16'(w_g8)
                  + 16'(LUMA_B) * 16'(w_b8);

    always_comb begin
        o_data_c = i_pix;
        case (i_fmt)
            FMT_RGB444: o_data_c = {4'h0, w_r5[4:1], w_g6[5:2], w_b5[4:1]};
            FMT_GRAY8:  o_data_c = {8'h00, w_luma[15:8]};
            default:    o_data_c = i_pix;
        endcase
    end

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 capture engine: oversampled camera bus -> decimated, format-converted frame-buffer writes.
module ov7670_frame_capture
    import ov7670_pkg::*;
#(
    parameter  int unsigned SRC_WIDTH  = 640,
    parameter  int unsigned SRC_HEIGHT = 480,
    parameter  int unsigned DECIM      = 4,
    localparam int unsigned IMG_WIDTH  = SRC_WIDTH / DECIM,
    localparam int unsigned IMG_HEIGHT = SRC_HEIGHT / DECIM,
    localparam int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pclk,
    input  logic                  href,
    input  logic                  vsync,
    input  logic [7:0]            data,
    input  logic [1:0]            fmt,
    input  logic                  cont,
    input  logic                  capture_req,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [15:0]           wData,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic                  line_err
);

    localparam int unsigned CW  = 16;
    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  L_DECIM = CW'(DECIM);
    localparam logic [CW-1:0]  L_IMG_W = CW'(IMG_WIDTH);
    localparam logic [CW-1:0]  L_IMG_H = CW'(IMG_HEIGHT);
    localparam logic [CW-1:0]  L_SRC_W = CW'(SRC_WIDTH);
    localparam logic [AW1-1:0] L_IMG_N = AW1'(IMG_WIDTH * IMG_HEIGHT);

    logic [10:0]    r_sync1, r_sync2, r_sync3;
    logic           r_href_d, r_vsync_d;
    logic           r_toggle;
    logic [7:0]     r_hi;
    logic [15:0]    r_pix;
    logic           r_pix_vld;
    logic [CW-1:0]  r_pix_x, r_pix_y;
    logic [CW-1:0]  r_x, r_y;
    logic [AW1-1:0] r_addr;
    pix_fmt_e       r_fmt;
    cap_state_e     r_state;
    logic           r_pend;

    logic           w_pclk_rise, w_href, w_vsync;
    logic [7:0]     w_data;
    logic           w_href_fall, w_vs_rise, w_vs_fall;
    logic           w_err_set, w_keep, w_write;
    logic [15:0]    w_conv;

    assign w_pclk_rise = r_sync2[10] & ~r_sync3[10];
    assign w_href      = r_sync3[9];
    assign w_vsync     = r_sync3[8];
    assign w_data      = r_sync3[7:0];
    assign w_href_fall = r_href_d & ~w_href;
    assign w_vs_rise   = ~r_vsync_d & w_vsync;
    assign w_vs_fall   = r_vsync_d & ~w_vsync;
    assign w_err_set   = w_href_fall & (r_toggle | (r_x != L_SRC_W));

    assign w_keep  = (r_pix_x % L_DECIM == '0) && (r_pix_y % L_DECIM == '0)
                  && (r_pix_x / L_DECIM < L_IMG_W) && (r_pix_y / L_DECIM < L_IMG_H);
    assign w_write = r_pix_vld && (r_state == ST_CAPTURE) && w_keep && (r_addr < L_IMG_N);

    ov7670_pix_convert u_convert (
        .i_fmt    (r_fmt),
        .i_pix    (r_pix),
        .o_data_c (w_conv)
    );

    // Synchronizers, byte pairing and x/y position tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync3   <= '0;
            r_href_d  <= 1'b0;
            r_vsync_d <= 1'b0;
            r_toggle  <= 1'b0;
            r_hi      <= '0;
            r_pix     <= '0;
            r_pix_vld <= 1'b0;
            r_pix_x   <= '0;
            r_pix_y   <= '0;
            r_x       <= '0;
            r_y       <= '0;
        end else begin
            r_sync1   <= {pclk, href, vsync, data};
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_href_d  <= w_href;
            r_vsync_d <= w_vsync;
            r_pix_vld <= 1'b0;
            if (w_pclk_rise && w_href) begin
                r_toggle <= ~r_toggle;
                if (!r_toggle) begin
                    r_hi <= w_data;
                end else begin
                    r_pix     <= {r_hi, w_data};
                    r_pix_vld <= 1'b1;
                    r_pix_x   <= r_x;
                    r_pix_y   <= r_y;
                    if (r_x != '1) r_x <= r_x + CW'(1);
                end
            end
            if (w_href_fall) begin
                r_x      <= '0;
                r_toggle <= 1'b0;
                if (r_y != '1) r_y <= r_y + CW'(1);
            end
            if (w_vs_rise) r_y <= '0;
        end
    end

    // Frame-buffer write port
    always_ff @(posedge clk) begin
        if (reset) begin
            we     <= 1'b0;
            wAddr  <= '0;
            wData  <= '0;
            r_addr <= '0;
        end else begin
            we <= 1'b0;
            if (w_vs_rise) begin
                r_addr <= '0;
                wAddr  <= '0;
            end else if (w_write) begin
                we     <= 1'b1;
                wAddr  <= r_addr[ADDR_WIDTH-1:0];
                wData  <= w_conv;
                r_addr <= r_addr + AW1'(1);
            end
        end
    end

    // Capture control: arm, wait for a clean frame start, capture, report
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pend     <= 1'b0;
            r_fmt      <= FMT_RGB565;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            line_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (capture_req && (r_state != ST_IDLE)) r_pend <= 1'b1;
            if (w_err_set)        line_err <= 1'b1;
            else if (capture_req) line_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cont || capture_req) begin
                        r_state <= ST_ARM;
                        busy    <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (w_vsync) r_state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (w_vs_fall) begin
                        r_fmt   <= (fmt == 2'd3) ? FMT_RGB565 : pix_fmt_e'(fmt);
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_vs_rise) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        busy       <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_pend <= 1'b0;
                    if (cont || r_pend || capture_req) begin
                        r_state <= ST_ARM;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Self-checking bench: drives a synthetic camera bus and compares writes against a frame model.
module tb_ov7670_frame_capture;

    localparam int SW  = 16;
    localparam int SH  = 8;
    localparam int DEC = 4;
    localparam int IW  = SW / DEC;
    localparam int IH  = SH / DEC;
    localparam int AW  = $clog2(IW * IH);

    logic          clk = 1'b0;
    logic          reset, pclk, href, vsync, cont, capture_req;
    logic [7:0]    data;
    logic [1:0]    fmt;
    logic          we, busy, frame_done, line_err;
    logic [AW-1:0] wAddr;
    logic [15:0]   wData, frame_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_fc = 0;

    logic [15:0] px [SH][SW];
    int          rc [SH][SW];
    int          got_a[$], got_c[$];
    logic [15:0] got_d[$];
    int          exp_a[$], exp_x[$], exp_y[$];
    logic [15:0] exp_d[$];
    int          fd_cnt = 0;
    logic        fd_busy = 1'b0, fd_prev_busy = 1'b0, prev_busy = 1'b0;

    ov7670_frame_capture #(.SRC_WIDTH(SW), .SRC_HEIGHT(SH), .DECIM(DEC)) dut (
        .clk(clk), .reset(reset), .pclk(pclk), .href(href), .vsync(vsync), .data(data),
        .fmt(fmt), .cont(cont), .capture_req(capture_req), .we(we), .wAddr(wAddr),
        .wData(wData), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .line_err(line_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            got_a.push_back(int'(wAddr));
            got_d.push_back(wData);
            got_c.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_busy      = busy;
            fd_prev_busy = prev_busy;
        end
        prev_busy = busy;
    end

    function automatic logic [15:0] ref_conv(input logic [15:0] p, input int f);
        int r, g, b, rr, gg, bb;
        r = int'(p[15:11]); g = int'(p[10:5]); b = int'(p[4:0]);
        if (f == 1) return 16'((r / 2) * 256 + (g / 4) * 16 + (b / 2));
        if (f == 2) begin
            rr = r * 8 + r / 4; gg = g * 4 + g / 16; bb = b * 8 + b / 4;
            return 16'((77 * rr + 150 * gg + 29 * bb) / 256);
        end
        return p;
    endfunction

    task automatic fill(input int mode);
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                px[y][x] = (mode == 0) ? 16'(x + 16 * y) : 16'($urandom);
    endtask

    task automatic build_exp(input int f);
        int n = 0;
        exp_a.delete(); exp_d.delete(); exp_x.delete(); exp_y.delete();
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                if (x % DEC == 0 && y % DEC == 0 && x / DEC < IW && y / DEC < IH && n < IW * IH) begin
                    exp_a.push_back(n); exp_d.push_back(ref_conv(px[y][x], f));
                    exp_x.push_back(x); exp_y.push_back(y); n++;
                end
    endtask

    task automatic clear_got();
        got_a.delete(); got_d.delete(); got_c.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output int rise);
        pclk = 1'b0; data = b;
        repeat (3) @(negedge clk);
        pclk = 1'b1; rise = cyc;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_lines(input int y0, input int y1, input int bad_y, input int req_y);
        int r;
        for (int y = y0; y <= y1; y++) begin
            href = 1'b1;
            for (int x = 0; x < SW; x++) begin
                send_byte(px[y][x][15:8], r);
                if (!(y == bad_y && x == SW - 1)) begin
                    send_byte(px[y][x][7:0], r);
                    rc[y][x] = r;
                end
            end
            pclk = 1'b0;
            repeat (3) @(negedge clk);
            href = 1'b0;
            repeat (8) @(negedge clk);
            if (y == req_y) begin
                capture_req = 1'b1; @(negedge clk); capture_req = 1'b0;
            end
        end
    endtask

    task automatic frame_begin();
        vsync = 1'b1; repeat (20) @(negedge clk);
        vsync = 1'b0; repeat (10) @(negedge clk);
    endtask

    task automatic frame_end();
        vsync = 1'b1; repeat (20) @(negedge clk);
    endtask

    task automatic send_frame(input int bad_y, input int req_y);
        frame_begin();
        send_lines(0, SH - 1, bad_y, req_y);
        frame_end();
    endtask

    task automatic test_reset();
        reset = 1'b1; pclk = 1'b0; href = 1'b0; vsync = 1'b1; data = 8'h00;
        fmt = 2'd0; cont = 1'b0; capture_req = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
        total++; if (wAddr !== '0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", wAddr); end
        total++; if (wData !== 16'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0000", wData); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        total++; if (frame_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
        total++; if (line_err !== 1'b0) begin bad++; $display("FAIL reset_lerr got=%b exp=0", line_err); end
    endtask

    task automatic test_basic();
        cont = 1'b1; fmt = 2'd0; fd_cnt = 0;
        fill(0); build_exp(0); clear_got();
        send_frame(-1, -1); exp_fc++;
        total++; if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL basic_nwrites got=%0d exp=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin bad++; $display("FAIL basic_write[%0d] got=%0d/%h exp=%0d/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
            total++;
            if (got_c[i] - rc[exp_y[i]][exp_x[i]] !== 4) begin bad++; $display("FAIL basic_latency[%0d] got=%0d exp=4", i, got_c[i] - rc[exp_y[i]][exp_x[i]]); end
        end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", fd_cnt); end
        total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL basic_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_back_to_back();
        int f;
        f = int'($urandom_range(0, 3));
        fmt = 2'(f);
        fill(1); build_exp(f); clear_got();
        send_frame(-1, -1); exp_fc++;
        total++; if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL b2b_nwrites got=%0d exp=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin bad++; $display("FAIL b2b_write[%0d] fmt=%0d got=%0d/%h exp=%0d/%h", i, f, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
        end
        total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL b2b_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_formats();
        fmt = 2'd2; fill(1);
        px[0][0] = 16'hFFFF; px[0][4] = 16'hF800; px[0][8] = 16'h0000;
        build_exp(2); clear_got();
        send_frame(-1, -1); exp_fc++;
        total++; if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL gray_nwrites got=%0d exp=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin bad++; $display("FAIL gray_write[%0d] got=%0d/%h exp=%0d/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
        end
        if (got_d.size() >= 3) begin
            total++; if (got_d[0] !== 16'h00FF) begin bad++; $display("FAIL gray_white got=%h exp=00ff", got_d[0]); end
            total++; if (got_d[1] !== 16'h004C) begin bad++; $display("FAIL gray_red got=%h exp=004c", got_d[1]); end
            total++; if (got_d[2] !== 16'h0000) begin bad++; $display("FAIL gray_black got=%h exp=0000", got_d[2]); end
        end
        // already armed: dropping cont here must still capture this frame
        cont = 1'b0; fmt = 2'd1; fill(1); px[0][0] = 16'hFFFF;
        build_exp(1); clear_got();
        send_frame(-1, -1); exp_fc++;
        total++; if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL rgb444_nwrites got=%0d exp=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin bad++; $display("FAIL rgb444_write[%0d] got=%0d/%h exp=%0d/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
        end
        if (got_d.size() >= 1) begin
            total++; if (got_d[0] !== 16'h0FFF) begin bad++; $display("FAIL rgb444_white got=%h exp=0fff", got_d[0]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_cont_drop busy=%b exp=0", busy); end
    endtask

    task automatic test_single_shot();
        fmt = 2'd0; fill(1); clear_got();
        send_frame(-1, 2);
        total++; if (got_a.size() != 0) begin bad++; $display("FAIL ss_partial_writes got=%0d exp=0", got_a.size()); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ss_armed_busy got=%b exp=1", busy); end
        fill(1); build_exp(0); clear_got(); fd_cnt = 0;
        send_frame(-1, -1); exp_fc++;
        total++; if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL ss_nwrites got=%0d exp=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin bad++; $display("FAIL ss_write[%0d] got=%0d/%h exp=%0d/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
        end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL ss_done_pulses got=%0d exp=1", fd_cnt); end
        total++; if (fd_busy !== 1'b0 || fd_prev_busy !== 1'b1) begin bad++; $display("FAIL ss_busy_edge got=%b->%b exp=1->0", fd_prev_busy, fd_busy); end
        total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL ss_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); end
        fill(1); clear_got();
        send_frame(-1, -1);
        total++; if (got_a.size() != 0 || fd_cnt != 1) begin bad++; $display("FAIL ss_after_writes got=%0d/%0d exp=0/1", got_a.size(), fd_cnt); end
    endtask

    task automatic test_line_err();
        total++; if (line_err !== 1'b0) begin bad++; $display("FAIL lerr_initial got=%b exp=0", line_err); end
        capture_req = 1'b1; @(negedge clk); capture_req = 1'b0;
        fmt = 2'd0; fill(1); build_exp(0); clear_got();
        send_frame(3, -1); exp_fc++;
        total++; if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL lerr_nwrites got=%0d exp=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin bad++; $display("FAIL lerr_write[%0d] got=%0d/%h exp=%0d/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
        end
        total++; if (line_err !== 1'b1) begin bad++; $display("FAIL lerr_set got=%b exp=1", line_err); end
        repeat (10) @(negedge clk);
        total++; if (line_err !== 1'b1) begin bad++; $display("FAIL lerr_sticky got=%b exp=1", line_err); end
        capture_req = 1'b1; @(negedge clk); capture_req = 1'b0;
        total++; if (line_err !== 1'b0) begin bad++; $display("FAIL lerr_clear got=%b exp=0", line_err); end
    endtask

    task automatic test_reset_mid();
        cont = 1'b1; fmt = 2'd0; fill(1); clear_got();
        frame_begin();
        send_lines(0, DEC, -1, -1);
        total++; if (got_a.size() != 2 * IW || busy !== 1'b1) begin bad++; $display("FAIL mid_precheck writes=%0d busy=%b exp=%0d/1", got_a.size(), busy, 2 * IW); end
        reset = 1'b1; @(negedge clk);
        total++;
        if ({we, busy, frame_done, line_err} !== 4'b0 || wAddr !== '0 || wData !== 16'h0 || frame_cnt !== 16'h0) begin
            bad++; $display("FAIL mid_reset_outputs we=%b busy=%b done=%b lerr=%b addr=%0d data=%h cnt=%0d exp=all zero",
                            we, busy, frame_done, line_err, wAddr, wData, frame_cnt);
        end
        reset = 1'b0; exp_fc = 0; clear_got();
        send_lines(DEC + 1, SH - 1, -1, -1);
        frame_end();
        total++; if (got_a.size() != 0) begin bad++; $display("FAIL mid_partial_writes got=%0d exp=0", got_a.size()); end
        total++; if (frame_cnt !== 16'h0) begin bad++; $display("FAIL mid_cnt_cleared got=%0d exp=0", frame_cnt); end
        fill(1); build_exp(0); clear_got();
        send_frame(-1, -1); exp_fc++;
        total++; if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL mid_nwrites got=%0d exp=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin bad++; $display("FAIL mid_write[%0d] got=%0d/%h exp=%0d/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
        end
        total++; if (frame_cnt !== 16'(exp_fc)) begin bad++; $display("FAIL mid_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_formats();
        test_single_shot();
        test_line_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
